// File: rtl/decoder_seq.sv
// One-hot decoder with a direct mode and a timed sweep mode (IDLE/SWEEP/DONE).
// Define DECODER_SEQ_ACTIVE_LOW_EN to drive Y one-cold (idle/reset at all-ones).
module decoder_seq #(
  parameter int N    = 3,
  parameter int HOLD = 1
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                En,
  input  logic                Mode,
  input  logic                Start,
  input  logic [N-1:0]        W,
  output logic [0:(1<<N)-1]   Y,
  output logic                Busy,
  output logic                Done,
  output logic [1:0]          state_dbg
);

  localparam int M = 1 << N;

`ifdef DECODER_SEQ_ACTIVE_LOW_EN
  localparam logic [0:M-1] POL = '1;
`else
  localparam logic [0:M-1] POL = '0;
`endif

  // Handshake: Start is a level sampled on a rising edge; it is honoured only
  // in IDLE with Mode=1 and En=1, and there is no acknowledge beyond Busy.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   idx, idx_n;
  logic [N-1:0]   steps, steps_n;
  logic [7:0]     hold, hold_n;
  logic [0:M-1]   y_n;
  logic           busy_n, done_n;

  function automatic logic [0:M-1] onehot(input logic [N-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    idx_n   = idx;
    steps_n = steps;
    hold_n  = hold;
    y_n     = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (Mode) begin
          if (En && Start) begin
            state_n = SWEEP;
            idx_n   = W;
            steps_n = '0;
            hold_n  = '0;
            y_n     = onehot(W);
            busy_n  = 1'b1;
          end
        end else if (En) begin
          y_n = onehot(W);
        end
      end
      SWEEP: begin
        busy_n = 1'b1;
        y_n    = onehot(idx);
        // A paused cycle (En=0) leaves idx, hold and Y untouched.
        if (En) begin
          if (hold == 8'(HOLD - 1)) begin
            hold_n = '0;
            if (steps == N'(M - 1)) begin
              state_n = DONE;
              y_n     = '0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              idx_n   = idx + 1'b1;
              steps_n = steps + 1'b1;
              y_n     = onehot(idx + 1'b1);
            end
          end else begin
            hold_n = hold + 8'd1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      idx   <= '0;
      steps <= '0;
      hold  <= '0;
      Y     <= POL;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      steps <= steps_n;
      hold  <= hold_n;
      Y     <= y_n ^ POL;
      Busy  <= busy_n;
      Done  <= done_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_decoder_seq.sv
// Randomised and directed bench for decoder_seq (N=3, HOLD=2) against a
// cycle-level reference built from elapsed-enabled-cycle arithmetic.
module tb_decoder_seq;

  localparam int N    = 3;
  localparam int HOLD = 2;
  localparam int M    = 1 << N;

`ifdef DECODER_SEQ_ACTIVE_LOW_EN
  localparam logic [0:M-1] POL = '1;
`else
  localparam logic [0:M-1] POL = '0;
`endif

  logic           Clock;
  logic           Resetn;
  logic           En;
  logic           Mode;
  logic           Start;
  logic [N-1:0]   W;
  logic [0:M-1]   Y;
  logic           Busy;
  logic           Done;
  logic [1:0]     state_dbg;

  decoder_seq #(.N(N), .HOLD(HOLD)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .En        (En),
    .Mode      (Mode),
    .Start     (Start),
    .W         (W),
    .Y         (Y),
    .Busy      (Busy),
    .Done      (Done),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: a sweep is described by its start index and the number
  // of enabled cycles elapsed since it began.
  logic [M+1:0] exp_q[$];
  bit           m_sweep, m_donep;
  int           m_s, m_e;

  function automatic logic [0:M-1] oh(input int i);
    logic [0:M-1] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int cur_idx();
    return (m_s + m_e / HOLD) % M;
  endfunction

  task automatic model_reset();
    m_sweep = 0;
    m_donep = 0;
    m_s     = 0;
    m_e     = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit en, input bit mode, input bit start, input int w);
    logic [0:M-1] ey;
    bit eb, ed;
    ey = '0; eb = 0; ed = 0;
    if (m_sweep) begin
      if (en) m_e++;
      if (m_e == M * HOLD) begin
        m_sweep = 0;
        m_donep = 1;
        ed      = 1;
      end else begin
        ey = oh(cur_idx());
        eb = 1;
      end
    end else if (m_donep) begin
      m_donep = 0;
    end else if (mode) begin
      if (en && start) begin
        m_sweep = 1;
        m_s     = w;
        m_e     = 0;
        ey      = oh(w);
        eb      = 1;
      end
    end else if (en) begin
      ey = oh(w);
    end
    exp_q.push_back({ey, eb, ed});
  endtask

  // Driver: inputs change at the falling edge, outputs are checked at the next one.
  task automatic step(input bit en, input bit mode, input bit start, input logic [N-1:0] w);
    logic [M+1:0] e;
    En = en; Mode = mode; Start = start; W = w;
    model_edge(en, mode, start, int'(w));
    @(posedge Clock);
    @(negedge Clock);
    e = exp_q.pop_front();
    check("y", 32'(Y), 32'(e[M+1:2] ^ POL));
    check("busy", 32'(Busy), 32'(e[1]));
    check("done", 32'(Done), 32'(e[0]));
    check("at_most_onehot", 32'($countones(Y ^ POL) <= 1), 32'd1);
  endtask

  task automatic apply_reset();
    Resetn = 1'b0;
    #1;
    check("rst_y", 32'(Y), 32'(POL));
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_hold_done", 32'(Done), 32'd0);
    Resetn = 1'b1;
  endtask

  logic [0:M-1] lit;
  int n;

  initial begin
    En = 0; Mode = 0; Start = 0; W = '0;
    Resetn = 1'b1;
    @(negedge Clock);
    apply_reset();

    // Direct decode: W=5 then blank
    step(1, 0, 0, 3'd5);
    lit = 8'b00000100;
    check("direct_w5", 32'(Y), 32'(lit ^ POL));
    step(0, 0, 0, 3'd5);
    check("direct_blank", 32'(Y), 32'(POL));
    step(1, 0, 0, 3'd0);
    lit = 8'b10000000;
    check("direct_w0", 32'(Y), 32'(lit ^ POL));
    step(1, 1, 0, 3'd3);

    // Sweep from 6 with wrap; done must land 16 cycles after the start edge
    step(1, 1, 1, 3'd6);
    n = 0;
    while (!Done && n < 40) begin
      step(1, 1, 0, 3'($urandom_range(0, M - 1)));
      n++;
    end
    check("sweep_len", 32'(n), 32'd16);
    step(1, 1, 0, 3'd0);
    check("after_done_busy", 32'(Busy), 32'd0);

    // Pause on index 2, first hold cycle
    step(1, 1, 1, 3'd0);
    n = 0;
    while (!(m_sweep && m_e == 2 * HOLD) && n < 40) begin
      step(1, 1, 0, 3'd0);
      n++;
    end
    check("pause_reached", 32'(cur_idx()), 32'd2);
    repeat (3) step(0, 1, 0, 3'd0);
    check("pause_busy", 32'(Busy), 32'd1);
    step(1, 1, 0, 3'd0);
    lit = oh(2);
    check("resume_idx2", 32'(Y), 32'(lit ^ POL));
    step(1, 1, 0, 3'd0);
    lit = oh(3);
    check("resume_idx3", 32'(Y), 32'(lit ^ POL));

    // Ignored Start/W/Mode during the remainder of this sweep
    n = 0;
    while (m_sweep && n < 40) begin
      step(1, n[0], 1, 3'd1);
      n++;
    end
    step(1, 0, 0, 3'd0);

    // Reset mid-sweep at index 4, then a fresh sweep from 0
    step(1, 1, 1, 3'd2);
    n = 0;
    while (!(m_sweep && cur_idx() == 4) && n < 40) begin
      step(1, 1, 0, 3'd0);
      n++;
    end
    check("reached_idx4", 32'(cur_idx()), 32'd4);
    apply_reset();
    step(1, 1, 1, 3'd0);
    lit = oh(0);
    check("new_sweep_0", 32'(Y), 32'(lit ^ POL));
    check("new_sweep_busy", 32'(Busy), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 5) == 0, 3'($urandom_range(0, M - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 SHALL have parameter N, default 3: select width; output count is 2^N.
REQ-002 SHALL have parameter HOLD, default 1: cycles each output stays asserted in sweep mode; legal range 1..255.
REQ-003 SHALL have port Clock  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port En  input  1  global enable; 0 blanks direct outputs and pauses a sweep.
REQ-006 SHALL have port Mode  input  1  0 = direct decode, 1 = sweep; sampled only in IDLE.
REQ-007 SHALL have port Start  input  1  single-cycle request to begin a sweep.
REQ-008 SHALL have port W  input  N  select index (direct) or sweep start index (sweep).
REQ-009 SHALL have port Y  output  2^N, indexed [0:2^N-1]  registered one-hot output; Y[k] high means index k selected.
REQ-010 SHALL have port Busy  output  1  high while in SWEEP.
REQ-011 SHALL have port Done  output  1  single-cycle pulse at sweep completion.

Function
REQ-012 SHALL implement the FSM states IDLE, SWEEP and DONE.
REQ-013 SHALL make every output a flop; there is no combinational path from any input to any output.
REQ-014 SHALL, in IDLE with Mode=0, load Y with onehot(W) when En=1 and all-zero when En=0, visible one cycle after sampling (latency 1).
REQ-015 SHALL, in IDLE with Mode=1, drive Y to all-zero.
REQ-016 SHALL, when Mode=1, En=1 and Start=1 in IDLE, latch W as start index S, go to SWEEP, and drive Y=onehot(S) on the next cycle.
REQ-017 SHALL, in SWEEP, hold each index for HOLD enabled cycles, then advance the index by +1 modulo 2^N (2^N-1 wraps to 0).
REQ-018 SHALL visit all 2^N indices exactly once, starting at S, so a sweep lasts 2^N*HOLD enabled cycles.
REQ-019 SHALL, after the last index's HOLD expires, go to DONE with Y=0, Busy=0 and Done=1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL, while En=0 in SWEEP, freeze the index, hold counter and Y; counting resumes from the same point when En returns to 1.
REQ-021 SHALL ignore Start in SWEEP and DONE, and ignore Start when Mode=0 or En=0.
REQ-022 SHALL ignore changes to Mode and W during SWEEP; they take effect only in IDLE.
REQ-023 SHALL keep Y at most one-hot in every cycle in every state.
REQ-024 SHALL assert Busy=1 exactly while the state is SWEEP, including paused cycles.

Reset
REQ-025 SHALL, on Resetn=0, immediately and asynchronously force state=IDLE, Y=0, Busy=0, Done=0, index=0 and hold counter=0.
REQ-026 SHALL, on reset asserted mid-sweep, abandon the sweep with no Done pulse.
REQ-027 SHALL resume normal operation on the first rising Clock edge after Resetn deasserts.

Configuration
REQ-028 SHALL use the macro DECODER_SEQ_ACTIVE_LOW_EN.
REQ-029 SHALL, with DECODER_SEQ_ACTIVE_LOW_EN defined, drive Y bitwise inverted (one-cold), resetting to all-ones and idling/blanking at all-ones; Busy and Done are unaffected.
REQ-030 SHALL, without DECODER_SEQ_ACTIVE_LOW_EN, drive Y active-high as described above.

Verification (N=3, HOLD=2, macro undefined unless stated)
REQ-031 SHALL verify direct decode: Mode=0, En=1, W=5 -> Y=00000100 one cycle later; En=0 -> Y=00000000 next cycle.
REQ-032 SHALL verify sweep with wrap: Mode=1, Start, W=6 -> Y index sequence 6,6,7,7,0,0,...,5,5 (16 cycles), then Done=1 for 1 cycle with Y=0, then IDLE.
REQ-033 SHALL verify pause: En=0 for 3 cycles while index=2 on its first HOLD cycle -> Y frozen at index 2 and Busy=1; after resume index 2 is held 1 more cycle, then advances to 3.
REQ-034 SHALL verify reset mid-sweep: Resetn=0 at index 4 -> Y=0, Busy=0 immediately, no Done; Start with W=0 after release -> a new sweep from 0.
REQ-035 SHALL verify ignored inputs: Start and W=1 pulsed during SWEEP -> sequence unchanged, sweep ends on the original schedule.
REQ-036 SHALL verify the macro-defined build: after reset Y=11111111; direct W=0 -> Y=01111111.
